instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 16, byte-address width.
- DEPTH, 64, memory size in bytes; power of two, 2 to 2^ADDR_W.
- INSTR_W, 16, instruction width; multiple of 8; INSTR_W/8 = NB bytes per fetch.
- WAIT_CYCLES, 1, extra access latency; 0 to 15.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-high.
- fetch_req, in, 1, fetch request.
- fetch_addr, in, ADDR_W, byte address of the instruction.
- fetch_ready, out, 1, the block can accept a request.
- instr_valid, out, 1, one-cycle response strobe.
- instr, out, INSTR_W, fetched instruction.
- fault, out, 2, response status: 00 ok, 01 misaligned, 10 out of range.
- ld_we, in, 1, program-load byte write enable.
- ld_addr, in, ADDR_W, program-load byte address.
- ld_data, in, 8, program-load byte.
- busy, out, 1, a fetch is outstanding.
REQ-003 One clock only; reset is synchronous and active-high, sampled on the rising edge of clk.

Function
REQ-004 Storage is DEPTH bytes, byte-addressable, little-endian: instr = {mem[a+NB-1], ..., mem[a+1], mem[a]}.
REQ-005 The state machine has three states: IDLE, WAIT, RESP.
REQ-006 IDLE: fetch_ready=1, busy=0; fetch_req=1 captures fetch_addr and moves to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-007 WAIT: fetch_ready=0, busy=1; a down-counter loaded with WAIT_CYCLES-1 moves to RESP when it reaches 0.
REQ-008 The memory is read on the clock edge that enters RESP, using the captured address; the fetch_addr value after acceptance has no effect.
REQ-009 RESP lasts exactly one cycle: instr_valid=1, busy=1, fetch_ready=0; next state is IDLE.
REQ-010 Latency from the accepting edge to instr_valid=1 is WAIT_CYCLES+1 cycles; back-to-back throughput is one fetch per WAIT_CYCLES+2 cycles.
REQ-011 fetch_req while fetch_ready=0 is ignored, not queued.
REQ-012 Misaligned fetch (a mod NB != 0): fault=01, instr=0, memory not read.
REQ-013 Out-of-range fetch (a+NB-1 >= DEPTH, evaluated at ADDR_W+1 bits so there is no wrap-around): fault=10, instr=0.
REQ-014 If both fault conditions hold, misaligned (01) takes priority.
REQ-015 instr and fault hold their last response value while instr_valid=0.
REQ-016 ld_we=1 writes ld_data to mem[ld_addr] on that edge in any state, including while a fetch is in flight.
REQ-017 ld_addr >= DEPTH: the write is dropped silently.
REQ-018 A load write and the fetch read hitting the same byte on the same edge: the read returns the old byte (read-before-write).
REQ-019 A load write during WAIT to a byte of the pending fetch is visible in the response.

Reset
REQ-020 reset=1: state=IDLE, counter=0, instr_valid=0, instr=0, fault=00, busy=0; fetch_ready=1 in the first cycle after reset deasserts.
REQ-021 Reset mid-fetch (WAIT or RESP) aborts the fetch with no instr_valid pulse.
REQ-022 Reset does not alter memory contents.
REQ-023 While reset=1, fetch_req is ignored and ld_we writes are dropped.

Verification (defaults unless stated)
REQ-024 Load mem[4]=0x34, mem[5]=0x12; fetch a=4 -> instr_valid exactly 2 cycles after accept, instr=0x1234, fault=00.
REQ-025 Fetch a=3 -> instr_valid after 2 cycles, instr=0x0000, fault=01; fetch a=62 -> ok; fetch a=64 -> fault=10; fetch a=0xFFFF -> fault=01.
REQ-026 With WAIT_CYCLES=3, fetch a=0 held high continuously -> instr_valid every 5 cycles, fetch_ready=0 for the 4 cycles between accepts.
REQ-027 Fetch a=8 (mem[8]=0xAA), write mem[8]=0x55 during WAIT -> instr[7:0]=0x55; write on the RESP-entry edge instead -> 0xAA.
REQ-028 Assert reset one cycle after accepting a=4 -> no instr_valid, outputs are zero the next cycle, a refetch of a=4 still returns 0x1234.
REQ-029 With INSTR_W=32 and DEPTH=256, load bytes 0x11,0x22,0x33,0x44 at 8..11; fetch a=8 -> instr=0x44332211; fetch a=10 -> fault=01.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-loadable instruction memory with a fixed wait-state fetch port.
// Fetches report misalignment or out-of-range as a fault instead of returning data.
module instr_fetch_mem #(
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 64,
   parameter int INSTR_W     = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fetch_req,
   input  logic [ADDR_W-1:0]  fetch_addr,
   output logic               fetch_ready,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [1:0]         fault,
   input  logic               ld_we,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [7:0]         ld_data,
   output logic               busy
);
   localparam int NB = INSTR_W / 8;
   localparam int MAW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t             state_q;
   logic [3:0]         cnt_q;
   logic [ADDR_W-1:0]  addr_q, rd_addr;
   logic [7:0]         mem_q [DEPTH];
   logic [INSTR_W-1:0] instr_q, rd_data;
   logic [1:0]         fault_q, rd_fault;
   logic               rd_en, mis, oor;
   // With no wait states the read happens on the accepting edge, straight from fetch_addr.
   assign rd_addr  = (state_q == IDLE) ? fetch_addr : addr_q;
   assign rd_en    = (state_q == IDLE && fetch_req && WAIT_CYCLES == 0) ||
                     (state_q == WAIT && cnt_q == '0);
   assign mis      = (rd_addr % ADDR_W'(NB)) != '0;
   assign oor      = ({1'b0, rd_addr} + (ADDR_W+1)'(NB - 1)) >= (ADDR_W+1)'(DEPTH);
   assign rd_fault = mis ? 2'b01 : oor ? 2'b10 : 2'b00;
   always_comb begin
      rd_data = '0;
      if (rd_fault == 2'b00)
         for (int b = 0; b < NB; b++)
            rd_data[8*b +: 8] = mem_q[MAW'(rd_addr + ADDR_W'(b))];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         instr_q <= '0;
         fault_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (fetch_req) begin
               addr_q  <= fetch_addr;
               cnt_q   <= CNT_INIT;
               state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: if (cnt_q == '0) state_q <= RESP;
                  else cnt_q <= cnt_q - 4'd1;
            RESP: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (rd_en) begin
            instr_q <= rd_data;
            fault_q <= rd_fault;
         end
      end
   end
   // Same-edge load writes land after the read above samples mem_q.
   always_ff @(posedge clk)
      if (!reset && ld_we && {1'b0, ld_addr} < (ADDR_W+1)'(DEPTH))
         mem_q[ld_addr[MAW-1:0]] <= ld_data;
   assign fetch_ready = state_q == IDLE;
   assign busy        = state_q != IDLE;
   assign instr_valid = state_q == RESP;
   assign instr       = instr_q;
   assign fault       = fault_q;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: scoreboard bench over three configurations (default, 3 wait states, 32-bit/256B).
module tb_instr_fetch_mem;
   typedef struct {
      logic [31:0] instr;
      logic [1:0]  fault;
      int          cyc;
   } exp_t;
   logic        clk = 0, reset = 1, ld_we = 0;
   logic [15:0] ld_addr = '0;
   logic [7:0]  ld_data = '0;
   logic        req [3];
   logic [15:0] fa [3];
   logic        rdy [3], vld [3], bsy [3];
   logic [1:0]  flt [3];
   logic [15:0] inst0, inst1;
   logic [31:0] inst2;
   logic [31:0] inst [3];
   exp_t        q0 [$], q1 [$], q2 [$];
   int          cyc = 0, total = 0, bad = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always_comb begin
      inst[0] = 32'(inst0);
      inst[1] = 32'(inst1);
      inst[2] = inst2;
   end
   instr_fetch_mem u_d0 (
      .clk(clk), .reset(reset), .fetch_req(req[0]), .fetch_addr(fa[0]), .fetch_ready(rdy[0]),
      .instr_valid(vld[0]), .instr(inst0), .fault(flt[0]), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_data(ld_data), .busy(bsy[0]));
   instr_fetch_mem #(.WAIT_CYCLES(3)) u_d1 (
      .clk(clk), .reset(reset), .fetch_req(req[1]), .fetch_addr(fa[1]), .fetch_ready(rdy[1]),
      .instr_valid(vld[1]), .instr(inst1), .fault(flt[1]), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_data(ld_data), .busy(bsy[1]));
   instr_fetch_mem #(.INSTR_W(32), .DEPTH(256)) u_d2 (
      .clk(clk), .reset(reset), .fetch_req(req[2]), .fetch_addr(fa[2]), .fetch_ready(rdy[2]),
      .instr_valid(vld[2]), .instr(inst2), .fault(flt[2]), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_data(ld_data), .busy(bsy[2]));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic int lat(input int k);
      return k == 1 ? 4 : 2;
   endfunction
   task automatic push(input int k, input logic [31:0] e, input logic [1:0] f);
      exp_t x;
      x.instr = e;
      x.fault = f;
      x.cyc   = cyc + lat(k);
      case (k)
         0: q0.push_back(x);
         1: q1.push_back(x);
         default: q2.push_back(x);
      endcase
   endtask
   function automatic int sz(input int k);
      return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
   endfunction
   task automatic drain(input int k);
      int n = 0;
      while (sz(k) != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sz(k)), 0);
      if (k == 0) q0.delete(); else if (k == 1) q1.delete(); else q2.delete();
   endtask
   task automatic fetch(input int k, input logic [15:0] a, input logic [31:0] e, input logic [1:0] f);
      int n = 0;
      @(negedge clk);
      while (!rdy[k] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready", 32'(rdy[k]), 1);
      req[k] = 1;
      fa[k]  = a;
      push(k, e, f);
      @(negedge clk);
      req[k] = 0;
      fa[k]  = 16'($urandom);
      drain(k);
      @(negedge clk);
      chk("hold_valid", 32'(vld[k]), 0);
      chk("hold_instr", inst[k], e);
      chk("hold_fault", 32'(flt[k]), 32'(f));
   endtask
   task automatic ld(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_we   = 1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_we = 0;
   endtask
   always @(negedge clk) if (vld[0]) begin
      exp_t x;
      if (q0.size() == 0) chk("spurious0", 32'(q0.size()), 1);
      else begin
         x = q0.pop_front();
         chk("instr0", inst[0], x.instr);
         chk("fault0", 32'(flt[0]), 32'(x.fault));
         chk("lat0", cyc, x.cyc);
      end
   end
   always @(negedge clk) if (vld[1]) begin
      exp_t x;
      if (q1.size() == 0) chk("spurious1", 32'(q1.size()), 1);
      else begin
         x = q1.pop_front();
         chk("instr1", inst[1], x.instr);
         chk("fault1", 32'(flt[1]), 32'(x.fault));
         chk("lat1", cyc, x.cyc);
      end
   end
   always @(negedge clk) if (vld[2]) begin
      exp_t x;
      if (q2.size() == 0) chk("spurious2", 32'(q2.size()), 1);
      else begin
         x = q2.pop_front();
         chk("instr2", inst[2], x.instr);
         chk("fault2", 32'(flt[2]), 32'(x.fault));
         chk("lat2", cyc, x.cyc);
      end
   end
   initial begin
      #400000;
      $display("FAIL timeout got=%0d cycles exp=finish", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      for (int k = 0; k < 3; k++) begin
         req[k] = 0;
         fa[k]  = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(vld[0]), 0);
      chk("rst_instr", inst[0], 0);
      chk("rst_fault", 32'(flt[0]), 0);
      chk("rst_busy", 32'(bsy[0]), 0);
      reset = 0;
      @(negedge clk);
      chk("rst_ready", 32'(rdy[0]), 1);
      ld(4, 8'h34); ld(5, 8'h12); ld(62, 8'hBE); ld(63, 8'hEF);
      ld(20, 8'h66); ld(21, 8'h00); ld(6, 8'h5A); ld(7, 8'hA5);
      ld(70, 8'hFF);
      fetch(0, 16'd4, 32'h1234, 2'b00);
      fetch(0, 16'd3, 32'h0, 2'b01);
      fetch(0, 16'd62, 32'hEFBE, 2'b00);
      fetch(0, 16'd64, 32'h0, 2'b10);
      fetch(0, 16'hFFFF, 32'h0, 2'b01);
      fetch(0, 16'hFFFE, 32'h0, 2'b10);
      fetch(0, 16'd6, 32'hA55A, 2'b00);
      // request held while busy is ignored and the new address does not leak in
      @(negedge clk);
      req[0] = 1; fa[0] = 16'd4;
      push(0, 32'h1234, 2'b00);
      @(negedge clk);
      chk("busy_wait", 32'(bsy[0]), 1);
      chk("ready_wait", 32'(rdy[0]), 0);
      fa[0] = 16'd62;
      @(negedge clk);
      chk("busy_resp", 32'(bsy[0]), 1);
      req[0] = 0;
      drain(0);
      repeat (4) @(negedge clk);
      // load on the RESP-entry edge: read-before-write
      ld(8, 8'hAA); ld(9, 8'h01);
      @(negedge clk);
      req[0] = 1; fa[0] = 16'd8;
      push(0, 32'h01AA, 2'b00);
      @(negedge clk);
      req[0] = 0;
      ld_we = 1; ld_addr = 16'd8; ld_data = 8'h55;
      @(negedge clk);
      ld_we = 0;
      drain(0);
      fetch(0, 16'd8, 32'h0155, 2'b00);
      // reset mid-fetch; writes and requests during reset are dropped
      @(negedge clk);
      req[0] = 1; fa[0] = 16'd4;
      @(negedge clk);
      req[0] = 0; reset = 1;
      ld_we = 1; ld_addr = 16'd20; ld_data = 8'h77;
      @(negedge clk);
      chk("mid_rst_valid", 32'(vld[0]), 0);
      chk("mid_rst_instr", inst[0], 0);
      chk("mid_rst_fault", 32'(flt[0]), 0);
      chk("mid_rst_busy", 32'(bsy[0]), 0);
      req[0] = 1;
      @(negedge clk);
      reset = 0; req[0] = 0; ld_we = 0;
      @(negedge clk);
      chk("post_rst_ready", 32'(rdy[0]), 1);
      fetch(0, 16'd4, 32'h1234, 2'b00);
      fetch(0, 16'd20, 32'h0066, 2'b00);
      // three wait states, request held high: one accept every 5 cycles
      ld(0, 8'hCD); ld(1, 8'hAB);
      @(negedge clk);
      req[1] = 1; fa[1] = 16'd0;
      for (int j = 0; j < 15; j++) begin
         chk("w3_ready", 32'(rdy[1]), 32'(j % 5 == 0));
         if (j % 5 == 0) push(1, 32'hABCD, 2'b00);
         if (j == 14) req[1] = 0;
         @(negedge clk);
      end
      drain(1);
      // load during a non-final wait cycle is visible
      ld(8, 8'hAA); ld(9, 8'h01);
      @(negedge clk);
      req[1] = 1; fa[1] = 16'd8;
      push(1, 32'h0155, 2'b00);
      @(negedge clk);
      req[1] = 0;
      ld_we = 1; ld_addr = 16'd8; ld_data = 8'h55;
      @(negedge clk);
      ld_we = 0;
      drain(1);
      // 32-bit instance
      ld(8, 8'h11); ld(9, 8'h22); ld(10, 8'h33); ld(11, 8'h44);
      ld(252, 8'h01); ld(253, 8'h02); ld(254, 8'h03); ld(255, 8'h04);
      fetch(2, 16'd8, 32'h44332211, 2'b00);
      fetch(2, 16'd10, 32'h0, 2'b01);
      fetch(2, 16'd252, 32'h04030201, 2'b00);
      fetch(2, 16'd256, 32'h0, 2'b10);
      repeat (5) @(negedge clk);
      chk("end_q0", 32'(q0.size()), 0);
      chk("end_q1", 32'(q1.size()), 0);
      chk("end_q2", 32'(q2.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
